lzd_shift_ctrl: RTL
===================

Name: lzd_shift_ctrl

Overview:
- Sequential leading-zero detector that produces the shift amount and direction for the normalization barrel shifter of the FP add/sub datapath.
- Captures an unnormalized significand (implicit bit + fraction + guard + round) after the add stage.
- Scans the significand MSB-first, CH bits per cycle, with early exit.
- Delivers Shift_Value_o, FSM_left_right_o and a zero flag with a one-cycle done strobe, which feeds the shifter's Shift_Value/left_right inputs and its load control.

Parameters:
- SW, 26: significand width incl. implicit, guard and round bits (55 for double).
- EW, 8: width of the shift-value output; 2^EW > SW is required.
- CH, 4: bits examined per scan cycle; 1 <= CH <= SW.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_i  input  1  start request; accepted only in IDLE.
- Add_Overflow_i  input  1  carry-out of the adder; forces a right shift by 1.
- Data_i  input  SW  significand to normalize, sampled on the accepting edge.
- busy_o  output  1  high in SCAN and DONE.
- done_o  output  1  one-cycle strobe; results are valid while high.
- Shift_Value_o  output  EW  shift amount.
- FSM_left_right_o  output  1  direction: 1 = left, 0 = right.
- zero_o  output  1  captured Data_i was all zeros.

Behaviour:
- Reset (asynchronous, active-high), and whenever rst is asserted, including mid-scan:
  - state = IDLE.
  - Data register, chunk index and count = 0.
  - Shift_Value_o = 0, FSM_left_right_o = 0, zero_o = 0, done_o = 0, busy_o = 0.
  - A scan in progress is abandoned with no done_o.
- States: IDLE, SCAN, DONE. done_o = (state == DONE). busy_o = (state != IDLE).
- IDLE:
  - load_i = 0: stay in IDLE.
  - load_i = 1 and Add_Overflow_i = 1: register Shift_Value_o = 1, FSM_left_right_o = 0, zero_o = 0, then go to DONE. Overflow has priority over Data_i content.
  - load_i = 1 and Add_Overflow_i = 0: capture Data_i, clear the chunk index k and count, go to SCAN.
- SCAN, per cycle, examines chunk k = bits [SW-1-k*CH : max(0, SW-(k+1)*CH)]. The last chunk may be narrower than CH (SW = 26, CH = 4 gives 7 chunks, the last 2 bits wide).
  - Chunk contains a 1: Shift_Value_o = count + number of leading zeros inside the chunk, FSM_left_right_o = 1, zero_o = 0, go to DONE.
  - Chunk all zero and not last: count += chunk width, k += 1, stay in SCAN.
  - Chunk all zero and last: Shift_Value_o = 0, FSM_left_right_o = 1, zero_o = 1, go to DONE.
- DONE: one cycle, then IDLE unconditionally. Outputs hold their value until the next result is registered.
- Latency from the accepting edge to done_o high:
  - Overflow: 1 cycle.
  - Scan: (k_found + 2) cycles, where k_found is the index of the first chunk containing a 1 (0-based).
  - Zero input: ceil(SW/CH) + 1 cycles.
- Already-normalized input (MSB = 1): Shift_Value_o = 0, left, latency 2.
- load_i asserted while busy_o = 1 is ignored and not queued. load_i in the same cycle as DONE is also ignored; the earliest restart is the cycle after done_o.
- Data_i changes after capture have no effect on the result.
- Arithmetic: count is EW bits wide; the maximum value is SW-1, so no saturation is needed.

Test Plan:
- Reset mid-scan: load Data_i = 26'h0000001, assert rst during cycle 3 -> all outputs 0, state IDLE, done_o never pulses; a new load then works normally.
- Normalized and near-normalized (SW = 26, CH = 4):
  - Data_i = 26'h2000000 -> done_o at cycle 2, Shift_Value_o = 0, left = 1.
  - Data_i = 26'h0800000 -> Shift_Value_o = 2, latency 2.
- Deep scan: Data_i = 26'h0000001 -> Shift_Value_o = 25, left = 1, zero_o = 0, done_o at cycle 8.
  - Data_i = 26'h0000080 -> Shift_Value_o = 18, done_o at cycle 6.
- Zero input: Data_i = 0 -> zero_o = 1, Shift_Value_o = 0, done_o at cycle 8.
- Overflow priority: Add_Overflow_i = 1 with Data_i = 26'h0000001 -> Shift_Value_o = 1, left = 0, done_o at cycle 1.
- Busy ignore: second load_i with different data during SCAN and on the DONE cycle -> first result unchanged, exactly one done_o.
- Back-to-back: load again the cycle after done_o -> accepted.

Source files
------------

// File: rtl/lzd_shift_ctrl.sv
// Sequential leading-zero detector for the FP add/sub normalization shifter.
// It scans the captured significand MSB-first, CH bits per cycle, and stops
// at the first chunk that holds a one. It then reports the shift amount, the
// shift direction and a zero flag, together with a one-cycle done strobe.
// An adder carry-out bypasses the scan and requests a right shift by one.
module lzd_shift_ctrl #(
  parameter int SW = 26,
  parameter int EW = 8,
  parameter int CH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          Add_Overflow_i,
  input  logic [SW-1:0] Data_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [EW-1:0] Shift_Value_o,
  output logic          FSM_left_right_o,
  output logic          zero_o
);

  localparam int NCH = (SW + CH - 1) / CH;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] data;
  logic [KW-1:0] k;
  logic [EW-1:0] count;

  logic [CH-1:0] chunk;
  logic          chunk_hit;
  logic          last_chunk;

  // The data register is shifted left by CH after each all-zero chunk, so the
  // chunk under test always sits in the top CH bits. The last chunk may be
  // narrower than CH; its missing low bits are zeros shifted in, which cannot
  // change either the hit test or the leading-zero count.
  assign chunk      = data[SW-1 -: CH];
  assign chunk_hit  = |chunk;
  assign last_chunk = (k == KW'(NCH - 1));

  // Number of leading zeros within one chunk, MSB first.
  function automatic logic [EW-1:0] chunk_lz(input logic [CH-1:0] c);
    logic [EW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (!found) begin
        if (c[i]) found = 1'b1;
        else      n     = n + EW'(1);
      end
    end
    return n;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. DONE always lasts one cycle, and load_i is only
  // honoured in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load_i) state_nxt = Add_Overflow_i ? DONE : SCAN;
      end
      SCAN: begin
        if (chunk_hit || last_chunk) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Scan datapath and registered results. Results hold until overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data             <= '0;
      k                <= '0;
      count            <= '0;
      Shift_Value_o    <= '0;
      FSM_left_right_o <= 1'b0;
      zero_o           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_i) begin
            if (Add_Overflow_i) begin
              Shift_Value_o    <= EW'(1);
              FSM_left_right_o <= 1'b0;
              zero_o           <= 1'b0;
            end else begin
              data  <= Data_i;
              k     <= '0;
              count <= '0;
            end
          end
        end
        SCAN: begin
          if (chunk_hit) begin
            Shift_Value_o    <= count + chunk_lz(chunk);
            FSM_left_right_o <= 1'b1;
            zero_o           <= 1'b0;
          end else if (last_chunk) begin
            Shift_Value_o    <= '0;
            FSM_left_right_o <= 1'b1;
            zero_o           <= 1'b1;
          end else begin
            data  <= data << CH;
            k     <= k + KW'(1);
            count <= count + EW'(CH);
          end
        end
        default: ;
      endcase
    end
  end

  assign done_o = (state == DONE);
  assign busy_o = (state != IDLE);

endmodule
